// File: rtl/arbiter_rr_reg.sv
// N-input valid/ready arbiter (round-robin or fixed priority) feeding a one-entry output register.
// Optional macro ARBITER_RR_SRC_ID_EN adds out_src, the channel index of the buffered beat.
module arbiter_rr_reg #(
  parameter int N          = 4,
  parameter int DWIDTH     = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          in_valid,
  input  logic [N*DWIDTH-1:0]   in_data,
  output logic [N-1:0]          in_ready,
  output logic                  out_valid,
  output logic [DWIDTH-1:0]     out_data,
  input  logic                  out_ready
`ifdef ARBITER_RR_SRC_ID_EN
  ,
  output logic [$clog2(N)-1:0]  out_src
`endif
);

  localparam int PW = $clog2(N);

  logic [PW-1:0]     ptr;
  logic [PW-1:0]     grant;
  logic [PW:0]       cand;
  logic              found;
  logic              any_req;
  logic              load;
  logic              xfer;
  logic [DWIDTH-1:0] grant_data;

  // Scan from ptr upward; the wrap is an explicit compare so non-power-of-2 N works.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(N)) begin
        cand = cand - (PW+1)'(N);
      end
      if (!found && in_valid[cand[PW-1:0]]) begin
        found = 1'b1;
        grant = cand[PW-1:0];
      end
    end
  end

  assign any_req    = |in_valid;
  assign load       = !out_valid || out_ready;
  assign xfer       = any_req && load && !rst;
  assign grant_data = in_data[grant*DWIDTH +: DWIDTH];

  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      ptr       <= '0;
`ifdef ARBITER_RR_SRC_ID_EN
      out_src   <= '0;
`endif
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
`ifdef ARBITER_RR_SRC_ID_EN
        out_src   <= grant;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // Fixed-priority mode leaves ptr at 0 so channel 0 always wins.
      if (xfer && (FIXED_PRIO == 0)) begin
        ptr <= (grant == PW'(N-1)) ? '0 : grant + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arbiter_rr_reg.sv
// Scoreboard bench for arbiter_rr_reg: a round-robin instance and a fixed-priority instance.
// Output beats are checked by monitors against queues filled as stimulus is issued.
module tb_arbiter_rr_reg;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] src;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [3:0]  fp_valid;
  logic [7:0]  chan [4];
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic [3:0]  fp_ready;
  logic        out_valid;
  logic        fp_out_valid;
  logic [7:0]  out_data;
  logic [7:0]  fp_out_data;
  logic        out_ready;
`ifdef ARBITER_RR_SRC_ID_EN
  logic [1:0]  out_src;
  logic [1:0]  fp_out_src;
`endif

  beat_t sb[$];
  beat_t fp_sb[$];
  beat_t mon_beat;
  beat_t fp_mon_beat;
  int    errors = 0;
  int    checks = 0;

  assign in_data = {chan[3], chan[2], chan[1], chan[0]};

  always #5 clk = ~clk;

  arbiter_rr_reg #(.N(4), .DWIDTH(8), .FIXED_PRIO(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef ARBITER_RR_SRC_ID_EN
    ,
    .out_src   (out_src)
`endif
  );

  arbiter_rr_reg #(.N(4), .DWIDTH(8), .FIXED_PRIO(1)) dut_fp (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (fp_valid),
    .in_data   (in_data),
    .in_ready  (fp_ready),
    .out_valid (fp_out_valid),
    .out_data  (fp_out_data),
    .out_ready (out_ready)
`ifdef ARBITER_RR_SRC_ID_EN
    ,
    .out_src   (fp_out_src)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives the round-robin instance for one cycle and checks its grant at the falling edge.
  task automatic apply_stimulus(input logic [3:0] vld, input logic ordy,
                                input logic [3:0] exp_rdy, input bit push);
    in_valid  = vld;
    out_ready = ordy;
    if (push) begin
      for (int k = 0; k < 4; k++) begin
        if (exp_rdy[k]) sb.push_back(beat_t'{data: chan[k], src: 2'(k)});
      end
    end
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
  endtask

  task automatic fp_stimulus(input logic [3:0] vld, input logic [3:0] exp_rdy, input bit push);
    fp_valid  = vld;
    out_ready = 1'b1;
    if (push) begin
      for (int k = 0; k < 4; k++) begin
        if (exp_rdy[k]) fp_sb.push_back(beat_t'{data: chan[k], src: 2'(k)});
      end
    end
    @(negedge clk);
    check("fp_in_ready", 32'(fp_ready), 32'(exp_rdy));
  endtask

  task automatic check_output(input string name, input logic exp_valid, input logic [7:0] exp_data);
    check({name, "_valid"}, 32'(out_valid), 32'(exp_valid));
    check({name, "_data"}, 32'(out_data), 32'(exp_data));
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat: got %0h expected none at %0t", out_data, $time);
      end else begin
        mon_beat = sb.pop_front();
        check("out_data", 32'(out_data), 32'(mon_beat.data));
`ifdef ARBITER_RR_SRC_ID_EN
        check("out_src", 32'(out_src), 32'(mon_beat.src));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (fp_out_valid && out_ready) begin
      if (fp_sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL fp_unexpected_beat: got %0h expected none at %0t", fp_out_data, $time);
      end else begin
        fp_mon_beat = fp_sb.pop_front();
        check("fp_out_data", 32'(fp_out_data), 32'(fp_mon_beat.data));
`ifdef ARBITER_RR_SRC_ID_EN
        check("fp_out_src", 32'(fp_out_src), 32'(fp_mon_beat.src));
`endif
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 4'hF;
    fp_valid  = 4'hF;
    out_ready = 1'b1;
    chan[0] = 8'h00; chan[1] = 8'h11; chan[2] = 8'h22; chan[3] = 8'h33;
    step();

    // Reset held with every channel requesting
    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'h0);
      check("rst_fp_in_ready", 32'(fp_ready), 32'h0);
      check_output("rst_out", 1'b0, 8'h00);
      step();
    end
    rst      = 1'b0;
    fp_valid = 4'h0;

    // All channels valid: grants rotate 0,1,2,3,0 with no bubbles
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(4'hF, 1'b1, 4'(1 << (i % 4)), 1'b1);
      if (i > 0) check("no_bubble", 32'(out_valid), 32'h1);
      step();
    end
    apply_stimulus(4'h0, 1'b1, 4'h0, 1'b0);
    check("last_beat_valid", 32'(out_valid), 32'h1);
    step();

    // Reset with a beat stalled in the output register discards it
    apply_stimulus(4'b0100, 1'b0, 4'b0100, 1'b0);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'h0);
    check_output("pre_rst_buf", 1'b1, 8'h22);
    step();
    rst = 1'b0;
    apply_stimulus(4'h0, 1'b1, 4'h0, 1'b0);
    check_output("post_rst", 1'b0, 8'h00);
    step();
    apply_stimulus(4'b1001, 1'b1, 4'b0001, 1'b1);
    step();

    // Sparse requesters 1 and 3, then ptr must have wrapped to 0
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(4'b1010, 1'b1, (i % 2 == 0) ? 4'b0010 : 4'b1000, 1'b1);
      step();
    end
    apply_stimulus(4'b1001, 1'b1, 4'b0001, 1'b1);
    step();

    // Backpressure on beat 0xA5 from channel 2, then drain+load in one cycle
    chan[2] = 8'hA5;
    chan[0] = 8'h5A;
    apply_stimulus(4'b0100, 1'b1, 4'b0100, 1'b1);
    step();
    repeat (5) begin
      apply_stimulus(4'b0001, 1'b0, 4'b0000, 1'b0);
      check_output("stall", 1'b1, 8'hA5);
      step();
    end
    apply_stimulus(4'b0001, 1'b1, 4'b0001, 1'b1);
    step();
    apply_stimulus(4'h0, 1'b1, 4'h0, 1'b0);
    check_output("refill", 1'b1, 8'h5A);
    step();

    // Beat 0x5C from channel 3 held through a stall
    chan[3] = 8'h5C;
    apply_stimulus(4'b1000, 1'b0, 4'b1000, 1'b1);
    step();
    repeat (3) begin
      apply_stimulus(4'h0, 1'b0, 4'h0, 1'b0);
      check_output("src_stall", 1'b1, 8'h5C);
`ifdef ARBITER_RR_SRC_ID_EN
      check("src_stall_src", 32'(out_src), 32'h3);
`endif
      step();
    end
    apply_stimulus(4'h0, 1'b1, 4'h0, 1'b0);
    step();

    // Fixed priority: channel 0 always wins over channel 3
    in_valid = 4'h0;
    repeat (4) begin
      fp_stimulus(4'b1001, 4'b0001, 1'b1);
      step();
    end
    fp_stimulus(4'b1000, 4'b1000, 1'b1);
    step();
    fp_stimulus(4'h0, 4'h0, 1'b0);
    step();

    repeat (2) step();
    check("sb_empty", 32'(sb.size()), 32'h0);
    check("fp_sb_empty", 32'(fp_sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arbiter_rr_reg.md
Name: arbiter_rr_reg

Overview:
- N-input, valid/ready, round-robin arbiter with a registered output slot.
- Parametrised successor of the 2-input fixed-priority arbiter wrapper; generalises channel count and data width.
- Adds rotating fairness, a one-entry output buffer with full throughput, and a fixed-priority fallback mode.
- Sits between multiple cicero_core producers (e.g. per-engine instruction/result streams) and a single shared consumer.

Parameters:
- N, 4, number of input channels; N >= 2.
- DWIDTH, 8, payload width per channel.
- FIXED_PRIO, 0, 1 = fixed priority (index 0 highest, pointer never moves); 0 = round-robin.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  N  per-channel valid.
- in_data  input  N*DWIDTH  channel i payload at bits [i*DWIDTH +: DWIDTH].
- in_ready  output  N  per-channel ready; at most one bit set per cycle.
- out_valid  output  1  registered output valid.
- out_data  output  DWIDTH  registered output payload.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset: rst is sampled on clk, synchronous, active-high.
  - out_valid=0, out_data=0, ptr=0.
  - in_ready=0 while rst is high.
- Load enable: load = !out_valid || out_ready.
- Grant selection (combinational):
  - Search for the first set in_valid bit starting at index ptr, ascending, wrapping N-1 to 0.
  - g = found index; any_req = |in_valid.
- Ready: in_ready[g] = load && any_req; all other bits 0. Must not depend on in_data.
- Transfer on channel g: in_valid[g] && in_ready[g].
  - Next cycle: out_valid=1 and out_data=in_data[g].
  - Latency is exactly 1 cycle from acceptance to out_valid.
- Output drain: if out_valid && out_ready and no new transfer, then out_valid<=0.
  - Drain and load in the same cycle is permitted; this gives 1 beat per cycle sustained.
- Stall: while out_valid && !out_ready:
  - out_data and out_valid are held stable;
  - in_ready = 0.
- Pointer update:
  - Round-robin: on a transfer, ptr <= (g+1) mod N.
  - No transfer: ptr holds.
  - FIXED_PRIO=1: ptr stays 0 permanently.
- Fairness: with all N inputs continuously valid and out_ready=1, grants cycle 0,1,..,N-1,0...
  - Any requester waits at most N-1 grants.
- Wrap: g=N-1 sets ptr to 0.
- A requester that drops valid before being granted is simply skipped. Producers must still hold valid/data until accepted (AXI-stream rule).
- Reset mid-operation: a buffered beat is discarded, out_valid=0, ptr=0; there is no partial state.
- Pointer width: $clog2(N). For non-power-of-2 N, the wrap must use explicit compare, not natural overflow.

Optional Feature:
- Macro: ARBITER_RR_SRC_ID_EN.
- Defined:
  - Adds port out_src  output  $clog2(N)  holding the index of the channel whose beat is in the output register.
  - Loaded together with out_data, held during stall, reset to 0.
- Undefined: the port and its register do not exist; behaviour is otherwise identical.

Test Plan:
- Reset: assert rst 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0 throughout; first grant after release goes to channel 0.
- Round-robin: N=4, DWIDTH=8, all valid, in_data={0x33,0x22,0x11,0x00}, out_ready=1 -> out_data sequence 0x00,0x11,0x22,0x33,0x00, one beat per cycle, no bubbles.
- Sparse / wrap: only channels 1 and 3 valid, ptr=0 -> grants 1,3,1,3; after the grant to 3, ptr=0.
- Backpressure: out_ready=0 for 5 cycles after a beat 0xA5 from channel 2 -> out_data=0xA5 held, in_ready=0. On out_ready=1, 0xA5 drains and the next beat loads in the same cycle.
- Fixed mode: FIXED_PRIO=1, channels 0 and 3 continuously valid -> channel 0 granted every cycle, channel 3 never granted until in_valid[0]=0.
- ARBITER_RR_SRC_ID_EN defined: beat 0x5C from channel 3 -> out_src=3 aligned with out_data=0x5C, held during stall.
